// File: rtl/top_seq_ctrl.sv
// Multi-cycle instruction sequencer: fetches one word over a ready/valid memory
// port, hands it to the datapath for one EXEC cycle, and halts on ebreak, fetch timeout or misaligned PC.
module top_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [7:0]  TIMEOUT  = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        imem_rsp_ready,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic [31:0] dnpc,
    input  logic        rf_wen_in,
    output logic        rf_wen,
    output logic [31:0] pc,
    output logic [31:0] instret,
    output logic        halted,
    output logic [1:0]  halt_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_REQ,
        S_FETCH_WAIT,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [1:0] HC_EBREAK    = 2'b01;
    localparam logic [1:0] HC_TIMEOUT   = 2'b10;
    localparam logic [1:0] HC_MISALIGN  = 2'b11;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instret_q, instret_d;
    logic [31:0] inst_q, inst_d;
    logic [1:0]  halt_code_q, halt_code_d;
    logic [7:0]  timeout_q, timeout_d;

    logic expire;
    logic is_ebreak;
    logic misaligned;

    // The current cycle is the last one the fetch may use; compared in 9 bits so TIMEOUT=0 behaves.
    assign expire     = ({1'b0, timeout_q} + 9'd1) >= {1'b0, TIMEOUT};
    assign is_ebreak  = (inst_q & 32'hFFF0_707F) == 32'h0010_0073;
    assign misaligned = dnpc[1:0] != 2'b00;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        instret_d      = instret_q;
        inst_d         = inst_q;
        halt_code_d    = halt_code_q;
        timeout_d      = timeout_q;
        imem_req_valid = 1'b0;
        imem_req_addr  = 32'h0;
        imem_rsp_ready = 1'b0;
        inst_valid     = 1'b0;
        rf_wen         = 1'b0;
        halted         = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d   = S_FETCH_REQ;
                timeout_d = 8'd0;
            end
            S_FETCH_REQ: begin
                imem_req_valid = 1'b1;
                imem_req_addr  = pc_q;
                timeout_d      = timeout_q + 8'd1;
                // A handshake in the expiry cycle still wins over the fault.
                if (imem_req_ready) begin
                    state_d = S_FETCH_WAIT;
                end else if (expire) begin
                    state_d     = S_HALT;
                    halt_code_d = HC_TIMEOUT;
                end
            end
            S_FETCH_WAIT: begin
                imem_rsp_ready = 1'b1;
                timeout_d      = timeout_q + 8'd1;
                if (imem_rsp_valid) begin
                    inst_d  = imem_rsp_data;
                    state_d = S_EXEC;
                end else if (expire) begin
                    state_d     = S_HALT;
                    halt_code_d = HC_TIMEOUT;
                end
            end
            S_EXEC: begin
                inst_valid = 1'b1;
                if (is_ebreak) begin
                    state_d     = S_HALT;
                    halt_code_d = HC_EBREAK;
                end else if (misaligned) begin
                    state_d     = S_HALT;
                    halt_code_d = HC_MISALIGN;
                end else begin
                    rf_wen    = rf_wen_in;
                    pc_d      = dnpc;
                    instret_d = instret_q + 32'd1;
                    timeout_d = 8'd0;
                    state_d   = S_FETCH_REQ;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            instret_q   <= 32'h0;
            inst_q      <= 32'h0;
            halt_code_q <= 2'b00;
            timeout_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instret_q   <= instret_d;
            inst_q      <= inst_d;
            halt_code_q <= halt_code_d;
            timeout_q   <= timeout_d;
        end
    end

    assign inst      = inst_q;
    assign pc        = pc_q;
    assign instret   = instret_q;
    assign halt_code = halt_code_q;

endmodule

// File: tb/tb_top_seq_ctrl.sv
// Directed bench for top_seq_ctrl: drives inputs and samples outputs on the falling edge.
module tb_top_seq_ctrl;

    localparam logic [31:0] RST_PC  = 32'h8000_0000;
    localparam logic [31:0] ADDI    = 32'h0010_0093;
    localparam logic [31:0] ADDI2   = 32'h0020_0113;
    localparam logic [31:0] EBREAK  = 32'h0010_0073;
    localparam logic [31:0] ECALL   = 32'h0000_0073;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        imem_rsp_ready;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] dnpc = 32'h0;
    logic        rf_wen_in = 1'b0;
    logic        rf_wen;
    logic [31:0] pc;
    logic [31:0] instret;
    logic        halted;
    logic [1:0]  halt_code;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_instret;

    always #5 clk = ~clk;

    top_seq_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_ready (imem_rsp_ready),
        .inst           (inst),
        .inst_valid     (inst_valid),
        .dnpc           (dnpc),
        .rf_wen_in      (rf_wen_in),
        .rf_wen         (rf_wen),
        .pc             (pc),
        .instret        (instret),
        .halted         (halted),
        .halt_code      (halt_code)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Leaves the DUT in its first FETCH_REQ cycle, sampled at a falling edge.
    task automatic apply_reset();
        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        rf_wen_in      = 1'b0;
        dnpc           = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_pc      = RST_PC;
        exp_instret = 32'h0;
        @(negedge clk);
    endtask

    // One full fetch/execute, starting at a falling edge in FETCH_REQ.
    task automatic fetch_exec(input logic [31:0] data, input int wait_cyc,
                              input logic [31:0] next_pc, input logic wen,
                              input logic [1:0] exp_code);
        int n_ready;
        int n_iv;
        logic bad_pc;
        logic exp_wen;
        n_ready = 0;
        n_iv    = 0;
        bad_pc  = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin
            errors++;
            $display("FAIL fetch_req: valid=%b addr=%h, required valid=1 addr=%h",
                     imem_req_valid, imem_req_addr, exp_pc);
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        for (int i = 0; i < wait_cyc; i++) begin
            if (imem_rsp_ready === 1'b1) n_ready++;
            if (inst_valid === 1'b1) n_iv++;
            if (pc !== exp_pc) bad_pc = 1'b1;
            if (i == wait_cyc - 1) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = data;
            end
            @(negedge clk);
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hDEAD_BEEF;
        dnpc      = next_pc;
        rf_wen_in = wen;
        #1;
        exp_wen = (exp_code == 2'b00) ? wen : 1'b0;
        checks++;
        if (inst_valid !== 1'b1 || inst !== data || rf_wen !== exp_wen) begin
            errors++;
            $display("FAIL exec: inst_valid=%b inst=%h rf_wen=%b, required 1 %h %b",
                     inst_valid, inst, rf_wen, data, exp_wen);
        end
        checks++;
        if (imem_req_valid !== 1'b0 || imem_rsp_ready !== 1'b0 || pc !== exp_pc) begin
            errors++;
            $display("FAIL exec_quiet: req_valid=%b rsp_ready=%b pc=%h, required 0 0 %h",
                     imem_req_valid, imem_rsp_ready, pc, exp_pc);
        end
        if (inst_valid === 1'b1) n_iv++;
        @(negedge clk);
        rf_wen_in = 1'b0;
        checks++;
        if (rf_wen !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_exec_en: rf_wen=%b inst_valid=%b, required 0 0", rf_wen, inst_valid);
        end
        checks++;
        if (n_ready != wait_cyc || n_iv != 1 || bad_pc) begin
            errors++;
            $display("FAIL wait_phase: rsp_ready_cycles=%0d inst_valid_pulses=%0d pc_moved=%b, required %0d 1 0",
                     n_ready, n_iv, bad_pc, wait_cyc);
        end
        if (exp_code == 2'b00) begin
            exp_pc      = next_pc;
            exp_instret = exp_instret + 32'd1;
        end
        checks++;
        if (pc !== exp_pc || instret !== exp_instret || halted !== (exp_code != 2'b00)
            || halt_code !== exp_code) begin
            errors++;
            $display("FAIL retire: pc=%h instret=%h halted=%b code=%b, required %h %h %b %b",
                     pc, instret, halted, halt_code, exp_pc, exp_instret, exp_code != 2'b00, exp_code);
        end
        $display("fetch inst=%h wait=%0d -> pc=%h instret=%0d halted=%b code=%b",
                 data, wait_cyc, pc, instret, halted, halt_code);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_data  = 32'h1234_5678;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (pc !== RST_PC || instret !== 32'h0 || inst !== 32'h0 || halt_code !== 2'b00) begin
            errors++;
            $display("FAIL reset_state: pc=%h instret=%h inst=%h code=%b, required %h 0 0 00",
                     pc, instret, inst, halt_code, RST_PC);
        end
        checks++;
        if (imem_req_valid !== 1'b0 || imem_rsp_ready !== 1'b0 || imem_req_addr !== 32'h0
            || inst_valid !== 1'b0 || rf_wen !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: req_v=%b rsp_r=%b addr=%h iv=%b wen=%b halted=%b, required all 0",
                     imem_req_valid, imem_rsp_ready, imem_req_addr, inst_valid, rf_wen, halted);
        end
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || imem_rsp_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs: req_v=%b rsp_r=%b, required 0 0", imem_req_valid, imem_rsp_ready);
        end
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
            errors++;
            $display("FAIL idle_to_fetch: req_v=%b addr=%h, required 1 %h", imem_req_valid, imem_req_addr, RST_PC);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        fetch_exec(ADDI, 1, exp_pc + 32'd4, 1'b1, 2'b00);
        fetch_exec(ADDI, 1, exp_pc + 32'd4, 1'b0, 2'b00);
        fetch_exec(ECALL, 1, exp_pc + 32'd4, 1'b1, 2'b00);
    endtask

    task automatic test_delayed_response();
        apply_reset();
        fetch_exec(ADDI2, 5, exp_pc + 32'd4, 1'b1, 2'b00);
    endtask

    task automatic test_timeout();
        apply_reset();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = ADDI;
        repeat (254) @(negedge clk);
        checks++;
        if (halted !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC || inst !== 32'h0) begin
            errors++;
            $display("FAIL timeout_last_cycle: halted=%b req_v=%b addr=%h inst=%h, required 0 1 %h 0",
                     halted, imem_req_valid, imem_req_addr, inst, RST_PC);
        end
        @(negedge clk);
        checks++;
        if (halted !== 1'b1 || halt_code !== 2'b10 || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_halt: halted=%b code=%b req_v=%b, required 1 10 0",
                     halted, halt_code, imem_req_valid);
        end
        imem_req_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (halted !== 1'b1 || halt_code !== 2'b10 || imem_req_valid !== 1'b0
            || imem_rsp_ready !== 1'b0 || inst !== 32'h0 || pc !== RST_PC) begin
            errors++;
            $display("FAIL halt_absorbing: halted=%b code=%b req_v=%b rsp_r=%b inst=%h pc=%h",
                     halted, halt_code, imem_req_valid, imem_rsp_ready, inst, pc);
        end
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
    endtask

    task automatic test_timeout_boundary();
        apply_reset();
        repeat (254) @(negedge clk);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        checks++;
        if (halted !== 1'b0 || imem_rsp_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_at_expiry: halted=%b rsp_ready=%b, required 0 1", halted, imem_rsp_ready);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = ADDI;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        dnpc = RST_PC + 32'd4;
        #1;
        checks++;
        if (halted !== 1'b0 || inst_valid !== 1'b1 || inst !== ADDI) begin
            errors++;
            $display("FAIL rsp_at_expiry: halted=%b inst_valid=%b inst=%h, required 0 1 %h",
                     halted, inst_valid, inst, ADDI);
        end
        @(negedge clk);
        checks++;
        if (pc !== RST_PC + 32'd4 || instret !== 32'd1 || imem_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL expiry_retire: pc=%h instret=%h req_v=%b, required %h 1 1",
                     pc, instret, imem_req_valid, RST_PC + 32'd4);
        end
    endtask

    task automatic test_ebreak();
        apply_reset();
        fetch_exec(ADDI, 1, exp_pc + 32'd4, 1'b1, 2'b00);
        fetch_exec(EBREAK, 1, exp_pc + 32'd4, 1'b1, 2'b01);
        imem_req_ready = 1'b1;
        rf_wen_in      = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (halt_code !== 2'b01 || pc !== RST_PC + 32'd4 || instret !== 32'd1
            || rf_wen !== 1'b0 || inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL ebreak_frozen: code=%b pc=%h instret=%h wen=%b iv=%b req_v=%b",
                     halt_code, pc, instret, rf_wen, inst_valid, imem_req_valid);
        end
        imem_req_ready = 1'b0;
        rf_wen_in      = 1'b0;
    endtask

    task automatic test_misaligned();
        apply_reset();
        fetch_exec(ADDI, 1, 32'h8000_0006, 1'b1, 2'b11);
    endtask

    task automatic test_instret_wrap();
        apply_reset();
        dut.instret_q = 32'hFFFF_FFFF;
        exp_instret   = 32'hFFFF_FFFF;
        fetch_exec(ADDI, 1, exp_pc + 32'd4, 1'b1, 2'b00);
    endtask

    task automatic test_reset_mid_fetch();
        apply_reset();
        fetch_exec(ADDI, 1, exp_pc + 32'd4, 1'b1, 2'b00);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        checks++;
        if (imem_rsp_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_fetch_wait: rsp_ready=%b, required 1", imem_rsp_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (pc !== RST_PC || instret !== 32'h0 || inst !== 32'h0 || imem_rsp_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_fetch_reset: pc=%h instret=%h inst=%h rsp_r=%b, required %h 0 0 0",
                     pc, instret, inst, imem_rsp_ready, RST_PC);
        end
        rst = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = ADDI;
        repeat (2) @(negedge clk);
        checks++;
        if (imem_rsp_ready !== 1'b0 || inst !== 32'h0 || inst_valid !== 1'b0
            || imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
            errors++;
            $display("FAIL stale_rsp_ignored: rsp_r=%b inst=%h iv=%b req_v=%b addr=%h",
                     imem_rsp_ready, inst, inst_valid, imem_req_valid, imem_req_addr);
        end
        imem_rsp_valid = 1'b0;
        exp_pc      = RST_PC;
        exp_instret = 32'h0;
        fetch_exec(ADDI2, 1, exp_pc + 32'd4, 1'b0, 2'b00);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_delayed_response();
        test_timeout();
        test_timeout_boundary();
        test_ebreak();
        test_misaligned();
        test_instret_wrap();
        test_reset_mid_fetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/top_seq_ctrl.md
TOP_SEQ_CTRL -- requirements
Module: top_seq_ctrl

Interface
REQ-001 Parameter RESET_PC, 32'h8000_0000, PC value loaded by reset.
REQ-002 Parameter TIMEOUT, 8'd255, max cycles per fetch (request + response) before fault.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_ready  input  1  memory accepts request.
REQ-007 imem_req_addr  output  32  fetch address, equals pc.
REQ-008 imem_rsp_valid  input  1  fetch response valid.
REQ-009 imem_rsp_data  input  32  fetched instruction word.
REQ-010 imem_rsp_ready  output  1  controller accepts response.
REQ-011 inst  output  32  latched instruction driven to the decoder.
REQ-012 inst_valid  output  1  datapath executes inst this cycle.
REQ-013 dnpc  input  32  next PC computed by the datapath.
REQ-014 rf_wen_in  input  1  decoder register-write enable.
REQ-015 rf_wen  output  1  gated register-file write enable.
REQ-016 pc  output  32  architectural PC.
REQ-017 instret  output  32  retired-instruction counter.
REQ-018 halted  output  1  controller stopped.
REQ-019 halt_code  output  2  00 none, 01 ebreak, 10 fetch timeout, 11 misaligned dnpc.

Function
REQ-020 States SHALL be IDLE, FETCH_REQ, FETCH_WAIT, EXEC, HALT; encoding is free.
REQ-021 IDLE -> FETCH_REQ unconditionally on the next edge with rst low; no outputs are active in IDLE.
REQ-022 FETCH_REQ: imem_req_valid=1 and imem_req_addr=pc, both held stable until imem_req_valid & imem_req_ready; the handshake moves the FSM to FETCH_WAIT.
REQ-023 FETCH_WAIT: imem_rsp_ready=1; imem_rsp_valid latches imem_rsp_data into inst and moves the FSM to EXEC.
REQ-024 An 8-bit timeout counter SHALL clear on entry to FETCH_REQ and increment each cycle in FETCH_REQ/FETCH_WAIT; reaching TIMEOUT with no completing handshake -> HALT, halt_code=10.
REQ-025 A handshake and timeout expiry in the same cycle SHALL resolve as the handshake; no fault.
REQ-026 EXEC SHALL last exactly one cycle, with inst_valid=1 and rf_wen=rf_wen_in.
REQ-027 EXEC with ebreak ((inst & 32'hFFF0_707F)==32'h0010_0073) -> HALT, halt_code=01, rf_wen=0, pc and instret unchanged.
REQ-028 EXEC with non-ebreak and dnpc[1:0]!=0 -> HALT, halt_code=11, rf_wen=0, pc and instret unchanged.
REQ-029 Otherwise EXEC SHALL perform pc<=dnpc and instret<=instret+1 (modulo 2^32, wraps to 0), then go to FETCH_REQ.
REQ-030 HALT is absorbing until rst: halted=1, halt_code held, all request/enable outputs 0.
REQ-031 Best-case latency is 3 cycles per instruction (FETCH_REQ, FETCH_WAIT, EXEC) when ready/valid return in the same cycle they are awaited.
REQ-032 imem_rsp_valid outside FETCH_WAIT SHALL be ignored (imem_rsp_ready=0); inst SHALL change only on a FETCH_WAIT handshake.
REQ-033 rf_wen and inst_valid SHALL be 0 in every state except EXEC.

Reset
REQ-034 rst high at an edge SHALL set state=IDLE, pc=RESET_PC, instret=0, inst=0, halt_code=00, timeout=0, and all outputs 0 except pc, in any state including mid-handshake.
REQ-035 A response for a request outstanding across reset SHALL be discarded.

Verification
REQ-036 Release rst, memory always ready and responds next cycle with addi (32'h0010_0093), dnpc=pc+4 -> req addr 8000_0000, then 8000_0004; instret=1 after the first EXEC; one instruction retires every 3 cycles.
REQ-037 Response delayed 5 cycles -> imem_rsp_ready stays 1 for 5 cycles; inst_valid pulses exactly once; pc unchanged until EXEC.
REQ-038 Memory never asserts imem_req_ready -> halted=1, halt_code=10 after 255 cycles in FETCH_REQ; imem_req_valid then 0.
REQ-039 Fetch 32'h0010_0073 with rf_wen_in=1 -> HALT, halt_code=01, rf_wen=0, pc and instret frozen.
REQ-040 dnpc=32'h8000_0006 -> halt_code=11, pc stays; separately, preset instret to FFFF_FFFF, retire one instruction -> instret=0.
REQ-041 Assert rst during FETCH_WAIT, then drive imem_rsp_valid -> response ignored; fetch restarts at RESET_PC with instret=0.
